regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 77 +++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the register file and the arbiter.
// The arbiter uses the slave modport; the requester/regfile side uses the master modport.
interface regfile_wb_arbiter_if #(
  parameter int DW = 32
);
  logic          a_valid;
  logic [4:0]    a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [4:0]    b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          rf_hold;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   rf_wsel_n;
  logic [15:0]   conf_cnt;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, rf_hold,
    output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, rf_wsel_n, conf_cnt
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rf_hold,
    input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, rf_wsel_n, conf_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging ALU (A) and load (B) writebacks onto one register
// file write port, with a one-cycle registered write and a saturating conflict counter.
module regfile_wb_arbiter #(
    parameter int DW = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);

    typedef enum logic {LP_A, LP_B} lp_t;

    lp_t           lp_p1;
    logic          vld_p1;
    logic [4:0]    waddr_p1;
    logic [DW-1:0] wdata_p1;
    logic [15:0]   cnt_p1;

    logic grant_a;
    logic grant_b;
    logic conflict;

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    // Stage 0: combinational grant; reset gates readies so nothing is accepted while held
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        conflict = bus.a_valid & bus.b_valid & ~bus.rf_hold;
        if (rst_n && !bus.rf_hold) begin
            if (bus.a_valid && bus.b_valid) begin
                if (lp_p1 == LP_B) grant_a = 1'b1;
                else               grant_b = 1'b1;
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    // Stage 1: registered write; address 0 is accepted but never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_p1    <= LP_B;
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            cnt_p1   <= '0;
        end else begin
            if (grant_a) begin
                lp_p1    <= LP_A;
                waddr_p1 <= bus.a_addr;
                wdata_p1 <= bus.a_data;
                vld_p1   <= (bus.a_addr != 5'd0);
            end else if (grant_b) begin
                lp_p1    <= LP_B;
                waddr_p1 <= bus.b_addr;
                wdata_p1 <= bus.b_data;
                vld_p1   <= (bus.b_addr != 5'd0);
            end else begin
                vld_p1   <= 1'b0;
            end
            if (conflict) cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.rf_we     = vld_p1;
    assign bus.rf_waddr  = waddr_p1;
    assign bus.rf_wdata  = wdata_p1;
    assign bus.rf_wsel_n = vld_p1 ? ~(32'd1 << waddr_p1) : 32'hFFFF_FFFF;
    assign bus.conf_cnt  = cnt_p1;

endmodule
